axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_mem_pkg.sv | 28 ++
 rtl/axi_if.sv | 54 +++++
 rtl/axi_mem_array.sv | 29 ++
 rtl/axi_slave_mem.sv | 206 ++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state types and small helpers for the AXI4 slave memory.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Only full 32-bit beats are supported.
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // A burst is malformed for this slave unless it is word-sized FIXED or INCR.
  function automatic logic fmt_bad(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || !((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

  // True when addr falls inside [base, base + bytes).
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base,
                                   input logic [31:0] bytes);
    return (addr >= base) && ((addr - base) < bytes);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bundle (32-bit address/data) with master and slave views.
interface axi_if #(parameter int ID_WIDTH = 4);

  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid,                   output wready,
    output bid, bresp, bvalid,                            input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid,              input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input  awready,
    output wdata, wstrb, wlast, wvalid,                   input  wready,
    input  bid, bresp, bvalid,                            output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input  arready,
    input  rid, rdata, rresp, rlast, rvalid,              output rready
  );

endinterface

// File: rtl/axi_mem_array.sv
// Word-organised storage: one byte-strobed synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module axi_mem_array #(
  parameter int MEM_DEPTH = 1024,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk_wr,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wstrb,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_DEPTH];

  // Byte-lane write; lanes with a clear strobe keep their old value.
  always_ff @(posedge clk_wr) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word memory. Independent write (AW/W/B) and read
// (AR/R) FSMs, one outstanding transaction per direction, plus saturating
// counters of completed bursts exposed on debug_status.
module axi_slave_mem
  import axi_mem_pkg::*;
#(
  parameter int          ID_WIDTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          MEM_DEPTH = 1024
) (
  input  logic        clk_wr,
  input  logic        rst_wr_n,
  axi_if.slave        s_axi_if,
  output logic [31:0] debug_status
);

  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH) * 32'd4;

  // ---------------- write channel state ----------------
  w_state_e            w_state;
  logic [ID_WIDTH-1:0] w_id;
  logic [31:0]         w_addr;
  logic [7:0]          w_len;
  logic [7:0]          w_cnt;
  logic [1:0]          w_burst;
  logic                w_bad;     // size/burst illegal for the whole burst
  logic                w_err;     // sticky error from earlier beats
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [15:0]         wr_bursts;

  // ---------------- read channel state ----------------
  r_state_e            r_state;
  logic [31:0]         r_addr;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [1:0]          r_burst;
  logic                r_bad;
  logic                arready_q, rvalid_q, rlast_q;
  logic [1:0]          rresp_q;
  logic [31:0]         rdata_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [15:0]         rd_bursts;

  // ---------------- datapath ----------------
  logic              w_in_range, w_final, w_beat_err, aw_bad, mem_we;
  logic [31:0]       rd_addr_nxt, mem_rdata, rd_word;
  logic              rd_in_range, ar_bad;
  logic [IDX_W-1:0]  w_idx, r_idx;

  assign aw_bad     = fmt_bad(s_axi_if.awsize, s_axi_if.awburst);
  assign ar_bad     = fmt_bad(s_axi_if.arsize, s_axi_if.arburst);
  assign w_in_range = addr_ok(w_addr, BASE_ADDR, MEM_BYTES);
  assign w_final    = (w_cnt == w_len);
  assign w_beat_err = !w_in_range || (s_axi_if.wlast != w_final);
  assign mem_we     = (w_state == W_DATA) && s_axi_if.wvalid && w_in_range && !w_bad;
  assign w_idx      = IDX_W'((w_addr - BASE_ADDR) >> 2);

  // Address of the beat about to be loaded into the R output registers:
  // the AR address on acceptance, otherwise the successor of the current beat.
  always_comb begin
    rd_addr_nxt = r_addr;
    if (r_state == R_IDLE)          rd_addr_nxt = s_axi_if.araddr;
    else if (r_burst == BURST_INCR) rd_addr_nxt = r_addr + 32'd4;
  end

  assign rd_in_range = addr_ok(rd_addr_nxt, BASE_ADDR, MEM_BYTES);
  assign r_idx       = IDX_W'((rd_addr_nxt - BASE_ADDR) >> 2);
  assign rd_word     = rd_in_range ? mem_rdata : 32'd0;

  axi_mem_array #(.MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk_wr (clk_wr),
    .we     (mem_we),
    .waddr  (w_idx),
    .wstrb  (s_axi_if.wstrb),
    .wdata  (s_axi_if.wdata),
    .raddr  (r_idx),
    .rdata  (mem_rdata)
  );

  // Write FSM: accept AW, consume beats until the counter reaches awlen, then hold B.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      w_state   <= W_IDLE;
      w_id      <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= BURST_FIXED;
      w_bad     <= 1'b0;
      w_err     <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      wr_bursts <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_if.awvalid) begin
          w_id      <= s_axi_if.awid;
          w_addr    <= s_axi_if.awaddr;
          w_len     <= s_axi_if.awlen;
          w_burst   <= s_axi_if.awburst;
          w_bad     <= aw_bad;
          w_cnt     <= '0;
          w_err     <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          w_state   <= W_DATA;
        end
        W_DATA: if (s_axi_if.wvalid) begin
          if (w_burst == BURST_INCR) w_addr <= w_addr + 32'd4;
          w_cnt <= w_cnt + 8'd1;
          w_err <= w_err | w_beat_err;
          if (w_final) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bid_q    <= w_id;
            bresp_q  <= (w_err || w_beat_err || w_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state  <= W_RESP;
          end
        end
        W_RESP: if (s_axi_if.bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state   <= W_IDLE;
          if (wr_bursts != 16'hFFFF) wr_bursts <= wr_bursts + 16'd1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: R outputs are registered, so they stay put under backpressure and
  // a same-edge write is seen only on later beats.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= BURST_FIXED;
      r_bad     <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rid_q     <= '0;
      rd_bursts <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_if.arvalid) begin
          r_addr    <= rd_addr_nxt;
          r_len     <= s_axi_if.arlen;
          r_burst   <= s_axi_if.arburst;
          r_bad     <= ar_bad;
          r_cnt     <= '0;
          rid_q     <= s_axi_if.arid;
          rdata_q   <= rd_word;
          rresp_q   <= (!rd_in_range || ar_bad) ? RESP_SLVERR : RESP_OKAY;
          rlast_q   <= (s_axi_if.arlen == 8'd0);
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          r_state   <= R_DATA;
        end
        R_DATA: if (s_axi_if.rready) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
            if (rd_bursts != 16'hFFFF) rd_bursts <= rd_bursts + 16'd1;
          end else begin
            r_addr  <= rd_addr_nxt;
            r_cnt   <= r_cnt + 8'd1;
            rdata_q <= rd_word;
            rresp_q <= (!rd_in_range || r_bad) ? RESP_SLVERR : RESP_OKAY;
            rlast_q <= ((r_cnt + 8'd1) == r_len);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi_if.awready = awready_q;
  assign s_axi_if.wready  = wready_q;
  assign s_axi_if.bvalid  = bvalid_q;
  assign s_axi_if.bresp   = bresp_q;
  assign s_axi_if.bid     = bid_q;
  assign s_axi_if.arready = arready_q;
  assign s_axi_if.rvalid  = rvalid_q;
  assign s_axi_if.rlast   = rlast_q;
  assign s_axi_if.rresp   = rresp_q;
  assign s_axi_if.rdata   = rdata_q;
  assign s_axi_if.rid     = rid_q;

  assign debug_status = {rd_bursts, wr_bursts};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Bench for axi_slave_mem: directed table, hand sequences for multi-cycle
// corners, and randomized bursts checked against a word-array reference model.
module tb_axi_slave_mem;
  import axi_mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dbg;

  always #5 clk = ~clk;

  axi_if #(.ID_WIDTH(4)) bus();

  axi_slave_mem #(.ID_WIDTH(4), .BASE_ADDR(BASE), .MEM_DEPTH(DEPTH)) dut (
    .clk_wr       (clk),
    .rst_wr_n     (rst_n),
    .s_axi_if     (bus),
    .debug_status (dbg)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mdl [DEPTH];
  int          mdl_wr = 0;
  int          mdl_rd = 0;
  logic [31:0] wq_d [$];
  logic [3:0]  wq_s [$];
  logic [31:0] rq_d [$];
  logic [1:0]  rq_r [$];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  wsize;
    logic [1:0]  wburst;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    logic [2:0]  rsize;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == BURST_INCR) ? a + 32'(4 * i) : a;
  endfunction

  // Write burst from wq_d/wq_s. early>=0 puts wlast on that beat only;
  // abort>=0 pulses reset while that beat is presented.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int early,
                           input int stall, input int abort, output logic [1:0] resp);
    bit          bad = (size != 3'b010) || !(burst == BURST_FIXED || burst == BURST_INCR);
    bit          err = bad;
    bit          lastv;
    logic [31:0] a;
    logic [1:0]  exp;
    int          t;
    resp = 2'bxx;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = 8'(len); bus.awsize = size; bus.awburst = burst;
    t = 0;
    while (!bus.awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_ready", bus.awready, 1);
    @(posedge clk);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      lastv = (early >= 0) ? (i == early) : (i == len);
      bus.awvalid = 1'b0; bus.wvalid = 1'b1;
      bus.wdata = wq_d[i]; bus.wstrb = wq_s[i]; bus.wlast = lastv;
      if (i == abort) begin
        rst_n = 1'b0;
        #1;
        chk("abort_idle", {bus.awready, bus.wready, bus.bvalid, bus.arready}, 4'b1001);
        @(negedge clk);
        rst_n = 1'b1; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        mdl_wr = 0; mdl_rd = 0;
        return;
      end
      t = 0;
      while (!bus.wready && t < 50) begin @(negedge clk); t++; end
      chk("w_ready", bus.wready, 1);
      @(posedge clk);
      a = beat_addr(addr, burst, i);
      if (!in_rng(a)) err = 1;
      else if (!bad)
        for (int b = 0; b < 4; b++)
          if (wq_s[i][b]) mdl[widx(a)][8*b +: 8] = wq_d[i][8*b +: 8];
      if (lastv != (i == len)) err = 1;
    end
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("b_latency", bus.bvalid, 1);
    t = 0;
    while (!bus.bvalid && t < 50) begin @(negedge clk); t++; end
    exp = err ? 2'b10 : 2'b00;
    for (int s = 0; s < stall; s++) begin
      chk("b_hold", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, id, exp});
      @(negedge clk);
    end
    chk("b_resp", {bus.bvalid, bus.bid, bus.bresp}, {1'b1, id, exp});
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    mdl_wr++;
    chk("b_release", {bus.bvalid, bus.awready}, 2'b01);
  endtask

  // Read burst; every beat (and every stalled cycle) is compared with the model.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input int stall);
    bit          bad = (size != 3'b010) || !(burst == BURST_FIXED || burst == BURST_INCR);
    logic [31:0] a, exp_d;
    logic [1:0]  exp_r;
    int          t;
    rq_d.delete(); rq_r.delete();
    @(negedge clk);
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
    bus.arlen = 8'(len); bus.arsize = size; bus.arburst = burst;
    t = 0;
    while (!bus.arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_ready", bus.arready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a     = beat_addr(addr, burst, i);
      exp_d = in_rng(a) ? mdl[widx(a)] : 32'd0;
      exp_r = (!in_rng(a) || bad) ? 2'b10 : 2'b00;
      if (i == 0) chk("r_latency", bus.rvalid, 1);
      t = 0;
      while (!bus.rvalid && t < 50) begin @(negedge clk); t++; end
      for (int s = 0; s < stall; s++) begin
        chk("r_hold", {bus.rvalid, bus.rlast, bus.rresp, bus.rdata}, {1'b1, i == len, exp_r, exp_d});
        @(negedge clk);
      end
      chk("r_beat", {bus.rvalid, bus.rid, bus.rlast, bus.rresp, bus.rdata},
          {1'b1, id, i == len, exp_r, exp_d});
      rq_d.push_back(bus.rdata);
      rq_r.push_back(bus.rresp);
      bus.rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rready = 1'b0;
    end
    mdl_rd++;
    chk("r_release", {bus.rvalid, bus.arready}, 2'b01);
  endtask

  task automatic fill(input int n, input bit rnd, input logic [31:0] d, input logic [3:0] s);
    wq_d.delete(); wq_s.delete();
    for (int i = 0; i < n; i++) begin
      wq_d.push_back(rnd ? 32'($urandom) : d);
      wq_s.push_back(rnd ? 4'($urandom) : s);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [7];
    logic [1:0] resp;
    logic [31:0] a;
    int         len;
    logic [1:0] bu;
    logic [2:0] sz;

    tbl[0] = '{32'h1000, 32'hABCD_1234, 4'hF, 3'd2, BURST_INCR,  2'b00, 32'h1000, 3'd2, 32'hABCD_1234, 2'b00};
    tbl[1] = '{32'h0FFC, 32'hDEAD_BEEF, 4'hF, 3'd2, BURST_INCR,  2'b10, 32'h2000, 3'd2, 32'h0000_0000, 2'b10};
    tbl[2] = '{32'h1FFC, 32'h1122_3344, 4'hF, 3'd2, BURST_INCR,  2'b00, 32'h1FFC, 3'd2, 32'h1122_3344, 2'b00};
    tbl[3] = '{32'h1004, 32'hFFFF_FFFF, 4'h5, 3'd2, BURST_INCR,  2'b00, 32'h1004, 3'd2, 32'h00FF_00FF, 2'b00};
    tbl[4] = '{32'h1008, 32'hABAB_ABAB, 4'hF, 3'd3, BURST_INCR,  2'b10, 32'h1008, 3'd2, 32'h0000_0000, 2'b00};
    tbl[5] = '{32'h100C, 32'hCDCD_CDCD, 4'hF, 3'd2, BURST_WRAP,  2'b10, 32'h100C, 3'd2, 32'h0000_0000, 2'b00};
    tbl[6] = '{32'h1010, 32'h5A5A_5A5A, 4'hF, 3'd2, BURST_FIXED, 2'b00, 32'h1010, 3'd3, 32'h5A5A_5A5A, 2'b10};

    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Zero the whole array so the model and memory start identical.
    fill(256, 0, 32'd0, 4'hF);
    for (int k = 0; k < 4; k++)
      axi_write(BASE + 32'(k * 1024), 255, 3'd2, BURST_INCR, 4'd0, -1, 0, -1, resp);

    // Reset values, with nonzero counters beforehand.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_ready", {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast}, 6'b110000);
    chk("reset_resp_id", {bus.bresp, bus.rresp, bus.bid, bus.rid}, 12'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_debug", dbg, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_wr = 0; mdl_rd = 0;

    // Strobed INCR burst.
    wq_d = '{32'h0, 32'h1, 32'h200, 32'h0300_0000};
    wq_s = '{4'hF, 4'h1, 4'h2, 4'hC};
    axi_write(32'h1100, 3, 3'd2, BURST_INCR, 4'd3, -1, 0, -1, resp);
    chk("incr_bresp", resp, 2'b00);
    axi_read(32'h1100, 3, 3'd2, BURST_INCR, 4'd4, 0);
    chk("incr_beat0", rq_d[0], 32'h0000_0000);
    chk("incr_beat1", rq_d[1], 32'h0000_0001);
    chk("incr_beat2", rq_d[2], 32'h0000_0200);
    chk("incr_beat3", rq_d[3], 32'h0300_0000);
    chk("incr_debug", dbg, 32'h0001_0001);

    // Directed single-beat table.
    for (int i = 0; i < 7; i++) begin
      fill(1, 0, tbl[i].wdata, tbl[i].wstrb);
      axi_write(tbl[i].waddr, 0, tbl[i].wsize, tbl[i].wburst, 4'(i + 1), -1, 0, -1, resp);
      chk($sformatf("tbl%0d_bresp", i), resp, tbl[i].exp_bresp);
      axi_read(tbl[i].raddr, 0, tbl[i].rsize, BURST_INCR, 4'(i + 2), 0);
      chk($sformatf("tbl%0d_rdata", i), rq_d[0], tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_rresp", i), rq_r[0], tbl[i].exp_rresp);
    end

    // Backpressure on B and R.
    fill(2, 1, 0, 0);
    axi_write(32'h1020, 1, 3'd2, BURST_INCR, 4'd9, -1, 5, -1, resp);
    axi_read(32'h1020, 1, 3'd2, BURST_INCR, 4'd10, 5);

    // Malformed bursts: WRAP, 64-bit size, early wlast (zero data on a zero region).
    fill(2, 0, 32'hFFFF_FFFF, 4'hF);
    axi_write(32'h1300, 1, 3'd2, BURST_WRAP, 4'd1, -1, 0, -1, resp);
    chk("wrap_bresp", resp, 2'b10);
    fill(1, 0, 32'hFFFF_FFFF, 4'hF);
    axi_write(32'h1308, 0, 3'd3, BURST_INCR, 4'd2, -1, 0, -1, resp);
    chk("size_bresp", resp, 2'b10);
    fill(3, 0, 32'd0, 4'hF);
    axi_write(32'h1310, 2, 3'd2, BURST_INCR, 4'd3, 1, 0, -1, resp);
    chk("early_last_bresp", resp, 2'b10);
    axi_read(32'h1300, 7, 3'd2, BURST_INCR, 4'd4, 0);
    chk("wrap_nomod", rq_d[0], 32'd0);
    chk("size_nomod", rq_d[2], 32'd0);

    // Reset during beat 2 of a 4-beat write.
    fill(4, 1, 0, 0);
    axi_write(32'h1200, 3, 3'd2, BURST_INCR, 4'd5, -1, 0, 2, resp);
    repeat (3) begin
      chk("abort_no_b", {bus.bvalid, bus.awready}, 2'b01);
      @(negedge clk);
    end
    fill(1, 0, 32'h600D_F00D, 4'hF);
    axi_write(32'h1240, 0, 3'd2, BURST_INCR, 4'd6, -1, 0, -1, resp);
    chk("after_abort_bresp", resp, 2'b00);
    chk("after_abort_debug", dbg, 32'h0000_0001);
    axi_read(32'h1200, 3, 3'd2, BURST_INCR, 4'd7, 0);

    // Concurrent write and read on disjoint words.
    fill(4, 1, 0, 0);
    fork
      axi_write(32'h1400, 3, 3'd2, BURST_INCR, 4'd8, -1, 1, -1, resp);
      axi_read(32'h1100, 3, 3'd2, BURST_INCR, 4'd9, 1);
    join

    // Randomized bursts against the model.
    for (int n = 0; n < 30; n++) begin
      a   = 32'h0FF0 + 32'($urandom_range(0, 1032)) * 32'd4;
      len = int'($urandom_range(0, 5));
      case ($urandom_range(0, 9))
        0:       bu = BURST_WRAP;
        1:       bu = 2'b11;
        2, 3:    bu = BURST_FIXED;
        default: bu = BURST_INCR;
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      fill(len + 1, 1, 0, 0);
      axi_write(a, len, sz, bu, 4'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1,
                int'($urandom_range(0, 2)), -1, resp);
      if ($urandom_range(0, 1) == 0) a = 32'h0FF0 + 32'($urandom_range(0, 1032)) * 32'd4;
      axi_read(a, int'($urandom_range(0, 5)), ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2,
               ($urandom_range(0, 4) == 0) ? BURST_FIXED : BURST_INCR, 4'($urandom), int'($urandom_range(0, 2)));
    end

    chk("debug_final", dbg, {16'(mdl_rd), 16'(mdl_wr)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
